// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and parameter defaults.
package spi_pkg;

    localparam int SPI_DATA_W_DEF = 8;
    localparam int SPI_DIV_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_TRAIL = 2'd3
    } spi_state_e;

endpackage

// File: rtl/spi_baud_gen.sv
// Half-period timer: ticks once every div+1 cycles while load is low.
module spi_baud_gen
    import spi_pkg::*;
#(
    parameter int DIV_W = SPI_DIV_W_DEF
) (
    input  logic             PCLK,
    input  logic             PRESETN,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_reg;

    // The counter never exceeds div, so div = all-ones cannot wrap early.
    assign tick = !load && (cnt_reg == div);

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            cnt_reg <= '0;
        end else if (load || tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_shift_engine.sv
// SPI master shift engine: frame FSM, shift registers and SCK edge sequencing.
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W_DEF,
    parameter int DIV_W  = SPI_DIV_W_DEF
) (
    input  logic              PCLK,
    input  logic              PRESETN,
    input  logic              spi_en,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsbfe,
    input  logic [DIV_W-1:0]  div,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    input  logic              miso,
    output logic              mosi,
    output logic              sck,
    output logic              ss_n
);

    localparam int CNT_W = $clog2(2 * DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2 * DATA_W);

    spi_state_e        state_reg;
    logic [DATA_W-1:0] tx_sh_reg;
    logic [DATA_W-1:0] rx_sh_reg;
    logic [DATA_W-1:0] rx_data_reg;
    logic [CNT_W-1:0]  edge_cnt_reg;
    logic [DIV_W-1:0]  div_reg;
    logic              cpha_reg;
    logic              lsbfe_reg;
    logic              sck_reg;
    logic              mosi_reg;
    logic              rx_valid_reg;

    logic              tick;
    logic              idle;
    logic [CNT_W-1:0]  edge_num;
    logic              sample_edge;
    logic              last_edge;
    logic              tx_first;
    logic [DATA_W-1:0] tx_load_shift;
    logic              tx_out;
    logic [DATA_W-1:0] tx_shifted;

    spi_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .PCLK    (PCLK),
        .PRESETN (PRESETN),
        .load    (idle),
        .div     (div_reg),
        .tick    (tick)
    );

    assign idle     = (state_reg == ST_IDLE);
    assign tx_ready = idle && spi_en && PRESETN;
    assign busy     = !idle;
    assign ss_n     = idle;
    assign sck      = idle ? cpol : sck_reg;
    assign mosi     = mosi_reg;
    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;

    // Edges are numbered from 1; cpha=0 samples odd edges, cpha=1 samples even edges.
    assign edge_num    = edge_cnt_reg + CNT_W'(1);
    assign sample_edge = edge_num[0] ^ cpha_reg;
    assign last_edge   = (edge_num == LAST_EDGE);

    assign tx_first      = lsbfe ? tx_data[0] : tx_data[DATA_W-1];
    assign tx_load_shift = lsbfe ? (tx_data >> 1) : (tx_data << 1);
    assign tx_out        = lsbfe_reg ? tx_sh_reg[0] : tx_sh_reg[DATA_W-1];
    assign tx_shifted    = lsbfe_reg ? (tx_sh_reg >> 1) : (tx_sh_reg << 1);

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_reg    <= ST_IDLE;
            tx_sh_reg    <= '0;
            rx_sh_reg    <= '0;
            rx_data_reg  <= '0;
            edge_cnt_reg <= '0;
            div_reg      <= '0;
            cpha_reg     <= 1'b0;
            lsbfe_reg    <= 1'b0;
            sck_reg      <= 1'b0;
            mosi_reg     <= 1'b0;
            rx_valid_reg <= 1'b0;
        end else begin
            rx_valid_reg <= 1'b0;
            if (!spi_en) begin
                state_reg    <= ST_IDLE;
                edge_cnt_reg <= '0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (tx_valid) begin
                            state_reg    <= ST_LEAD;
                            div_reg      <= div;
                            cpha_reg     <= cpha;
                            lsbfe_reg    <= lsbfe;
                            sck_reg      <= cpol;
                            edge_cnt_reg <= '0;
                            rx_sh_reg    <= '0;
                            // cpha=0 needs the first bit valid before the first edge.
                            if (!cpha) begin
                                mosi_reg  <= tx_first;
                                tx_sh_reg <= tx_load_shift;
                            end else begin
                                tx_sh_reg <= tx_data;
                            end
                        end
                    end
                    ST_LEAD: begin
                        if (tick) begin
                            state_reg <= ST_SHIFT;
                        end
                    end
                    ST_SHIFT: begin
                        if (tick) begin
                            sck_reg      <= ~sck_reg;
                            edge_cnt_reg <= edge_num;
                            if (sample_edge) begin
                                rx_sh_reg <= lsbfe_reg ? {miso, rx_sh_reg[DATA_W-1:1]}
                                                       : {rx_sh_reg[DATA_W-2:0], miso};
                            end else if (!last_edge) begin
                                mosi_reg  <= tx_out;
                                tx_sh_reg <= tx_shifted;
                            end
                            if (last_edge) begin
                                state_reg <= ST_TRAIL;
                            end
                        end
                    end
                    ST_TRAIL: begin
                        if (tick) begin
                            state_reg    <= ST_IDLE;
                            rx_data_reg  <= rx_sh_reg;
                            rx_valid_reg <= 1'b1;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed self-checking bench for spi_shift_engine with a loopback/slave model on miso.
module tb_spi_shift_engine;

    logic       PCLK = 1'b0;
    logic       PRESETN = 1'b0;
    logic       spi_en = 1'b0;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic       lsbfe = 1'b0;
    logic [7:0] div = 8'd0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       miso;
    logic       mosi;
    logic       sck;
    logic       ss_n;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int lat;
    int cnt;

    // Bench-side view of the frame: edge counter, mosi capture and slave driver.
    logic       loop_en = 1'b1;
    logic       cap_cpha = 1'b0;
    logic       cap_lsbfe = 1'b0;
    logic [7:0] slave_data = 8'h00;
    logic       miso_drv = 1'b0;
    logic       sck_last = 1'b0;
    int         frame_edges = 0;
    int         last_edges = 0;
    logic [7:0] cap = 8'h00;
    logic [7:0] last_cap = 8'h00;

    assign miso = loop_en ? mosi : miso_drv;

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cyc <= cyc + 1;

    spi_shift_engine dut (
        .PCLK     (PCLK),
        .PRESETN  (PRESETN),
        .spi_en   (spi_en),
        .cpol     (cpol),
        .cpha     (cpha),
        .lsbfe    (lsbfe),
        .div      (div),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy),
        .miso     (miso),
        .mosi     (mosi),
        .sck      (sck),
        .ss_n     (ss_n)
    );

    always @(negedge PCLK) begin
        int bi;
        if (!busy) begin
            frame_edges = 0;
            cap = 8'h00;
            bi = cap_lsbfe ? 0 : 7;
            miso_drv = slave_data[bi];
        end else if (sck !== sck_last) begin
            frame_edges = frame_edges + 1;
            last_edges = frame_edges;
            if (frame_edges[0] != cap_cpha) begin
                cap = cap_lsbfe ? {mosi, cap[7:1]} : {cap[6:0], mosi};
                last_cap = cap;
            end else if (frame_edges < 16) begin
                bi = cap_lsbfe ? (frame_edges / 2) : (7 - frame_edges / 2);
                miso_drv = slave_data[bi];
            end
        end
        sck_last = sck;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [7:0] d);
        int n;
        n = 0;
        @(negedge PCLK);
        tx_data = d;
        tx_valid = 1'b1;
        while (!tx_ready && n < 50) begin
            @(negedge PCLK);
            n++;
        end
        chk("accept_ready", tx_ready, 1);
        @(posedge PCLK);
        #1;
        acc_cyc = cyc;
        tx_valid = 1'b0;
    endtask

    task automatic wait_rx(output int l);
        l = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge PCLK);
            #1;
            if (rx_valid) begin
                l = cyc - acc_cyc;
                break;
            end
        end
        $display("frame: rx_data=%02h latency=%0d edges=%0d mosi_cap=%02h", rx_data, l, last_edges, last_cap);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_ss_n"}, ss_n, 1);
        chk({pfx, "_sck"}, sck, cpol);
        chk({pfx, "_mosi"}, mosi, 0);
        chk({pfx, "_rx_data"}, rx_data, 0);
        chk({pfx, "_rx_valid"}, rx_valid, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_tx_ready"}, tx_ready, 0);
    endtask

    initial begin
        // Reset values, with spi_en high so tx_ready must be held low by reset.
        spi_en = 1'b1;
        @(negedge PCLK);
        chk_reset_outputs("rst");
        @(negedge PCLK);
        PRESETN = 1'b1;
        @(negedge PCLK);
        chk("idle_tx_ready", tx_ready, 1);
        cpol = 1'b1;
        #1;
        chk("idle_sck_cpol1", sck, 1);
        cpol = 1'b0;
        #1;
        chk("idle_sck_cpol0", sck, 0);

        // Mode 0, div 0, MSB first, loopback.
        loop_en = 1'b1; cap_cpha = 1'b0; cap_lsbfe = 1'b0;
        start(8'hA5);
        wait_rx(lat);
        chk("a_latency", lat, 18);
        chk("a_rx_data", rx_data, 8'hA5);
        chk("a_edges", last_edges, 16);
        chk("a_mosi", last_cap, 8'hA5);
        @(posedge PCLK);
        #1;
        chk("a_pulse_width", rx_valid, 0);

        // Mode 3, div 3, LSB first, slave returns 0x81.
        loop_en = 1'b0; slave_data = 8'h81;
        cpol = 1'b1; cpha = 1'b1; lsbfe = 1'b1; div = 8'd3;
        cap_cpha = 1'b1; cap_lsbfe = 1'b1;
        @(negedge PCLK);
        chk("b_sck_idle", sck, 1);
        start(8'h3C);
        repeat (7) @(posedge PCLK);
        #1;
        chk("b_sck_before_edge1", sck, 1);
        @(posedge PCLK);
        #1;
        chk("b_sck_edge1", sck, 0);
        wait_rx(lat);
        chk("b_latency", lat, 72);
        chk("b_rx_data", rx_data, 8'h81);
        chk("b_edges", last_edges, 16);
        chk("b_mosi", last_cap, 8'h3C);

        // Back-to-back frames with tx_valid held high.
        loop_en = 1'b1; cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0; div = 8'd0;
        cap_cpha = 1'b0; cap_lsbfe = 1'b0;
        @(negedge PCLK);
        tx_data = 8'h11;
        tx_valid = 1'b1;
        cnt = 0;
        while (!tx_ready && cnt < 50) begin
            @(negedge PCLK);
            cnt++;
        end
        @(posedge PCLK);
        #1;
        acc_cyc = cyc;
        tx_data = 8'h22;
        wait_rx(lat);
        chk("c1_latency", lat, 18);
        chk("c1_rx_data", rx_data, 8'h11);
        chk("c1_tx_ready", tx_ready, 1);
        chk("c1_busy", busy, 0);
        @(posedge PCLK);
        #1;
        chk("c_one_idle_gap", busy, 1);
        acc_cyc = cyc;
        tx_valid = 1'b0;
        wait_rx(lat);
        chk("c2_latency", lat, 18);
        chk("c2_rx_data", rx_data, 8'h22);

        // spi_en dropped at the 5th sck edge.
        div = 8'd1;
        start(8'hF0);
        cnt = 0;
        while (frame_edges != 5 && cnt < 200) begin
            @(negedge PCLK);
            #1;
            cnt++;
        end
        chk("d_reach_edge5", frame_edges, 5);
        spi_en = 1'b0;
        @(posedge PCLK);
        #1;
        chk("d_ss_n", ss_n, 1);
        chk("d_sck", sck, 0);
        chk("d_busy", busy, 0);
        chk("d_tx_ready", tx_ready, 0);
        cnt = 0;
        repeat (40) begin
            @(posedge PCLK);
            #1;
            if (rx_valid) cnt++;
        end
        chk("d_no_rx_valid", cnt, 0);
        chk("d_rx_hold", rx_data, 8'h22);
        spi_en = 1'b1;

        // Reset pulsed mid-frame, then a clean frame.
        start(8'h77);
        repeat (6) @(posedge PCLK);
        @(negedge PCLK);
        PRESETN = 1'b0;
        #1;
        chk_reset_outputs("e_rst");
        @(negedge PCLK);
        PRESETN = 1'b1;
        div = 8'd0;
        start(8'h5A);
        wait_rx(lat);
        chk("e_latency", lat, 18);
        chk("e_rx_data", rx_data, 8'h5A);
        chk("e_mosi", last_cap, 8'h5A);

        // Inputs changed during SHIFT must not affect the frame.
        start(8'hC3);
        repeat (4) @(posedge PCLK);
        #1;
        tx_data = 8'h00;
        cpha = 1'b1;
        wait_rx(lat);
        chk("f_latency", lat, 18);
        chk("f_rx_data", rx_data, 8'hC3);
        chk("f_mosi", last_cap, 8'hC3);
        chk("f_edges", last_edges, 16);
        cpha = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_shift_engine.md
SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8, frame length in bits.
REQ-002 SHALL have parameter DIV_W, default 8, width of the baud divisor.
REQ-003 SHALL have port PCLK  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port PRESETN  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port spi_en  input  1  engine enable; deassertion aborts any frame.
REQ-006 SHALL have port cpol  input  1  SCK idle level.
REQ-007 SHALL have port cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge.
REQ-008 SHALL have port lsbfe  input  1  1 = LSB first, 0 = MSB first.
REQ-009 SHALL have port div  input  DIV_W  SCK half-period is div+1 PCLK cycles.
REQ-010 SHALL have port tx_valid  input  1  frame request from the APB register block.
REQ-011 SHALL have port tx_data  input  DATA_W  frame to transmit.
REQ-012 SHALL have port tx_ready  output  1  engine accepts a frame this cycle.
REQ-013 SHALL have port rx_data  output  DATA_W  last received frame.
REQ-014 SHALL have port rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-015 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-016 SHALL have port miso  input  1  serial input.
REQ-017 SHALL have port mosi  output  1  serial output.
REQ-018 SHALL have port sck  output  1  serial clock.
REQ-019 SHALL have port ss_n  output  1  active-low slave select.

Function
REQ-020 SHALL implement the states IDLE, LEAD, SHIFT and TRAIL.
REQ-021 SHALL accept a frame when tx_valid and tx_ready are both high on a rising edge (the accept edge).
REQ-022 SHALL drive tx_ready = spi_en while in IDLE, and tx_ready = 0 in every other state.
REQ-023 SHALL latch tx_data, cpol, cpha, lsbfe and div on the accept edge; input changes during a frame SHALL have no effect.
REQ-024 SHALL sequence a frame as IDLE -> LEAD (div+1 cycles, ss_n low) -> SHIFT (2*DATA_W half-periods) -> TRAIL (div+1 cycles, ss_n low) -> IDLE.
REQ-025 SHALL toggle sck at the end of each SHIFT half-period, giving exactly 2*DATA_W edges per frame.
REQ-026 SHALL, in IDLE, drive sck combinationally equal to the live cpol input.
REQ-027 SHALL, when cpha = 0, present the first bit on mosi at LEAD entry, sample miso on odd edges (1, 3, ...) and shift mosi on even edges except the last.
REQ-028 SHALL, when cpha = 1, shift mosi on odd edges (the first bit appears on edge 1) and sample miso on even edges.
REQ-029 SHALL order bits by lsbfe for both mosi and rx_data assembly.
REQ-030 SHALL update rx_data and pulse rx_valid for exactly one cycle on the TRAIL -> IDLE transition, (div+1)*(2*DATA_W+2) cycles after the accept edge.
REQ-031 SHALL hold rx_data until the next completed frame.
REQ-032 SHALL allow tx_ready to rise in the cycle rx_valid pulses, so back-to-back frames have one IDLE cycle between them.
REQ-033 SHALL, when spi_en is low at any rising edge, move to IDLE next cycle with ss_n = 1, sck = cpol, no rx_valid and rx_data unchanged.
REQ-034 SHALL, for div = 0, produce one half-period per PCLK cycle; div = 2^DIV_W-1 SHALL not overflow the timer.
REQ-035 SHALL hold mosi at its last driven value while in IDLE.

Reset
REQ-036 SHALL, while PRESETN is low, force the state to IDLE and all counters to 0.
REQ-037 SHALL drive these output values during reset: ss_n = 1, sck = cpol, mosi = 0, rx_data = 0, rx_valid = 0, busy = 0, tx_ready = 0.
REQ-038 SHALL, on reset assertion mid-frame, abort the frame immediately with no rx_valid; after release, the first accept SHALL be possible on the first edge where spi_en and tx_valid are high.

Structure
REQ-039 SHALL place the state enum and the defaults for DATA_W and DIV_W in the shared package spi_pkg.
REQ-040 SHALL implement the half-period timer as sub-module spi_baud_gen (inputs: load, div; output: one-cycle tick at the end of each half-period).
REQ-041 SHALL keep the shift register, edge counter and FSM in spi_shift_engine.

Verification
REQ-042 Mode 0, div = 0, tx 0xA5, MSB first, miso looped to mosi -> 16 sck edges, rx_data = 0xA5, rx_valid 18 cycles after accept.
REQ-043 Mode 3, div = 3, lsbfe = 1, tx 0x3C, miso driven with 0x81 -> sck idles high, half-period 4 cycles, rx_data = 0x81, rx_valid 72 cycles after accept.
REQ-044 Back-to-back frames 0x11 then 0x22 with tx_valid held high -> exactly one IDLE cycle between frames, two rx_valid pulses.
REQ-045 spi_en dropped at the 5th sck edge -> ss_n = 1 and sck = cpol next cycle, no rx_valid, rx_data retains its previous value.
REQ-046 PRESETN pulsed low mid-frame -> all outputs at their REQ-037 reset values immediately; the next frame 0x5A completes correctly.
REQ-047 tx_data and cpha changed during SHIFT -> the transmitted bits and timing match the values latched at accept.
